// File: rtl/io6502_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io6502_pkg
//  Description : Shared constants for the 6502 board input port: register
//                addresses and pin counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package io6502_pkg;

  localparam int NUM_BUTTONS  = 5;
  localparam int NUM_SWITCHES = 16;

  // CPU-visible register addresses
  localparam logic [2:0] REG_SW_LO     = 3'd0;
  localparam logic [2:0] REG_SW_HI     = 3'd1;
  localparam logic [2:0] REG_BTN_STATE = 3'd2;
  localparam logic [2:0] REG_BTN_EVENT = 3'd3;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd4;

endpackage : io6502_pkg
`default_nettype wire

// File: rtl/input_port6502_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : 2-FF synchronizer plus debounce counter for one push-button.
//                The accepted level changes only after DEBOUNCE_CYCLES
//                consecutive synced samples that differ from it. 'rise' pulses
//                in the cycle whose closing edge accepts a 0->1 change, so a
//                flag set from it lands on the same edge as the level.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // Synced input has differed for the full debounce window on this cycle
  assign w_accept = (r_sync != r_level) && (r_cnt == c_cnt_last);

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
    end
  end

  // Count consecutive differing samples; any return to the stable level restarts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync == r_level) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_level <= r_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign level = r_level;
  assign rise  = w_accept & r_sync;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/input_port6502.sv
`default_nettype none
// ============================================================================
//  Module      : input_port6502
//  Description : Memory-mapped input port for the 6502 system. Synchronizes
//                the slide switches, debounces the push-buttons, latches
//                sticky press events and serves them as byte registers on the
//                synchronous-read CPU bus.
//                Optional macro INPUT_PORT6502_IRQ_EN adds the IRQ mask
//                register and a registered level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_port6502
  import io6502_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [NUM_BUTTONS-1:0]  buttons,
  input  logic                    cs,
  input  logic                    we,
  input  logic [2:0]              addr,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic                    irq
);

  localparam int c_pad_w = 8 - NUM_BUTTONS;

  logic [NUM_SWITCHES-1:0] r_sw_meta;
  logic [NUM_SWITCHES-1:0] r_sw_sync;
  logic [NUM_BUTTONS-1:0]  w_btn_level;
  logic [NUM_BUTTONS-1:0]  w_btn_rise;
  logic [NUM_BUTTONS-1:0]  r_event;
  logic [NUM_BUTTONS-1:0]  w_event_clr;
  logic [NUM_BUTTONS-1:0]  w_irq_mask;
  logic [7:0]              w_rd_data;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_unused;

  assign w_rd     = cs & ~we;
  assign w_wr     = cs & we;
  assign w_unused = ^data_in[7:NUM_BUTTONS];

  // Switches only need metastability protection, no debounce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (buttons[i]),
        .level   (w_btn_level[i]),
        .rise    (w_btn_rise[i])
      );
    end
  endgenerate

  assign w_event_clr = (w_wr && addr == REG_BTN_EVENT) ? data_in[NUM_BUTTONS-1:0] : '0;

  // Sticky press flags: write-1-to-clear, but a same-cycle press keeps the bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event <= '0;
    end else begin
      r_event <= (r_event & ~w_event_clr) | w_btn_rise;
    end
  end

`ifdef INPUT_PORT6502_IRQ_EN
  logic [NUM_BUTTONS-1:0] r_irq_mask;

  // IRQ mask register load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
    end else if (w_wr && addr == REG_IRQ_MASK) begin
      r_irq_mask <= data_in[NUM_BUTTONS-1:0];
    end
  end

  // Registered interrupt: follows flag/mask changes one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(r_event & r_irq_mask);
    end
  end

  assign w_irq_mask = r_irq_mask;
`else
  assign w_irq_mask = '0;
  assign irq        = 1'b0;
`endif

  // Read data selection; unmapped addresses (and the mask when absent) read 0
  always_comb begin
    w_rd_data = '0;
    case (addr)
      REG_SW_LO:     w_rd_data = r_sw_sync[7:0];
      REG_SW_HI:     w_rd_data = r_sw_sync[15:8];
      REG_BTN_STATE: w_rd_data = {{c_pad_w{1'b0}}, w_btn_level};
      REG_BTN_EVENT: w_rd_data = {{c_pad_w{1'b0}}, r_event};
      REG_IRQ_MASK:  w_rd_data = {{c_pad_w{1'b0}}, w_irq_mask};
      default:       w_rd_data = '0;
    endcase
  end

  // Read data register: captured on a read cycle, held otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (w_rd) begin
      data_out <= w_rd_data;
    end
  end

endmodule : input_port6502
`default_nettype wire

// File: tb/tb_input_port6502.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_port6502
//  Description : Self-checking bench for input_port6502 with DEBOUNCE_CYCLES=4.
//                Directed register-table and press/bounce/race sequences, then
//                random bus and button traffic compared against a cycle
//                reference model built from the register rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_port6502;

  localparam int DB = 4;
`ifdef INPUT_PORT6502_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] switches;
  logic [4:0]  buttons;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  input_port6502 #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .switches (switches),
    .buttons  (buttons),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [2:0] a);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Raw pin samples taken at the last two edges: [0] is two edges old, which
  // is what the register logic sees after the two synchronizer stages.
  logic [4:0]  m_bq [2];
  logic [15:0] m_sq [2];
  logic [4:0]  m_s, m_ev, m_mask, m_ev_nx;
  int          m_run [5];
  logic [7:0]  m_dout;
  logic        m_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_bq[0] = '0; m_bq[1] = '0; m_sq[0] = '0; m_sq[1] = '0;
      m_s = '0; m_ev = '0; m_mask = '0; m_dout = '0; m_irq = 1'b0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
    end else begin
      if (cs && !we) begin
        case (addr)
          3'd0:    m_dout = m_sq[0][7:0];
          3'd1:    m_dout = m_sq[0][15:8];
          3'd2:    m_dout = {3'b000, m_s};
          3'd3:    m_dout = {3'b000, m_ev};
          3'd4:    m_dout = IRQ_EN ? {3'b000, m_mask} : 8'h00;
          default: m_dout = 8'h00;
        endcase
      end
      m_irq   = IRQ_EN && ((m_ev & m_mask) != 5'b0);
      m_ev_nx = m_ev;
      if (cs && we && addr == 3'd3) m_ev_nx = m_ev_nx & ~data_in[4:0];
      if (cs && we && addr == 3'd4 && IRQ_EN) m_mask = data_in[4:0];
      for (int i = 0; i < 5; i++) begin
        if (m_bq[0][i] != m_s[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_s[i]   = m_bq[0][i];
            m_run[i] = 0;
            if (m_s[i]) m_ev_nx[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_ev    = m_ev_nx;
      m_bq[0] = m_bq[1]; m_bq[1] = buttons;
      m_sq[0] = m_sq[1]; m_sq[1] = switches;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rand_data_out", data_out, m_dout);
      check("rand_irq", {7'b0, irq}, {7'b0, m_irq});
    end
  end

  // ---------------- directed register table ----------------
  typedef struct {
    bit         wr;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h34, "sw_lo"};
    tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h12, "sw_hi"};
    tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'h00, "btn_state_idle"};
    tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00, "btn_event_idle"};
    tbl[4]  = '{1'b0, 3'd5, 8'h00, 8'h00, "addr5_zero"};
    tbl[5]  = '{1'b0, 3'd7, 8'h00, 8'h00, "addr7_zero"};
    tbl[6]  = '{1'b1, 3'd0, 8'hFF, 8'h00, ""};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 8'h34, "sw_lo_after_write"};
    tbl[8]  = '{1'b1, 3'd4, 8'hE3, 8'h00, ""};
    tbl[9]  = '{1'b0, 3'd4, 8'h00, IRQ_EN ? 8'h03 : 8'h00, "irq_mask_rd"};
    tbl[10] = '{1'b1, 3'd4, 8'h00, 8'h00, ""};

    reset_n = 1'b0; switches = '0; buttons = '0;
    cs = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    tick(3);
    check("por_data_out", data_out, 8'h00);
    check("por_irq", {7'b0, irq}, 8'h00);
    reset_n = 1'b1;

    // Switches: two-stage sync, then table of reads/writes
    switches = 16'h1234;
    tick(3);
    foreach (tbl[i]) begin
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
      else begin
        bus_read(tbl[i].a);
        check(tbl[i].name, data_out, tbl[i].exp);
      end
    end

    // Mid-run reset while button 3 is mid-debounce
    switches = 16'h0000;
    buttons  = 5'b01000;
    tick(3);
    reset_n = 1'b0;
    #1;
    check("rst_data_out_async", data_out, 8'h00);
    check("rst_irq_async", {7'b0, irq}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      bus_read(3'(a));
      check("post_rst_read", data_out, 8'h00);
    end
    bus_read(3'd3);
    check("rst_press_not_yet", data_out, 8'h00);
    bus_read(3'd3);
    check("rst_press_one_event", data_out, 8'h08);
    buttons = 5'b00000;
    tick(DB + 3);
    bus_write(3'd3, 8'hFF);
    bus_read(3'd3);
    check("event_cleared", data_out, 8'h00);

    // Clean press on button 0: level accepted on the 6th edge
    buttons = 5'b00001;
    tick(5);
    bus_read(3'd2);
    check("press_state_early", data_out, 8'h00);
    bus_read(3'd2);
    check("press_state", data_out, 8'h01);
    bus_read(3'd3);
    check("press_event", data_out, 8'h01);
    buttons = 5'b00000;
    tick(DB + 3);
    bus_read(3'd2);
    check("release_state", data_out, 8'h00);
    bus_read(3'd3);
    check("release_event_sticky", data_out, 8'h01);
    bus_write(3'd3, 8'h01);

    // Bounce on button 2: runs of 2 never qualify, then a clean hold
    for (int k = 0; k < 4; k++) begin
      buttons = (k % 2 == 0) ? 5'b00100 : 5'b00000;
      tick(2);
    end
    buttons = 5'b00100;
    tick(5);
    bus_read(3'd3);
    check("bounce_no_event", data_out, 8'h00);
    bus_read(3'd3);
    check("bounce_one_event", data_out, 8'h04);

    // W1C: set button 0 too, then clear only bit 0
    buttons = 5'b00101;
    tick(DB + 3);
    bus_read(3'd3);
    check("event_05", data_out, 8'h05);
    bus_write(3'd3, 8'h01);
    bus_read(3'd3);
    check("w1c_bit0", data_out, 8'h04);
    bus_write(3'd3, 8'h04);
    bus_read(3'd3);
    check("w1c_bit2", data_out, 8'h00);

    // Race: clear bit 2 on the same edge button 2 is re-accepted
    buttons = 5'b00001;
    tick(DB + 3);
    buttons = 5'b00101;
    tick(5);
    bus_write(3'd3, 8'h04);
    bus_read(3'd3);
    check("set_wins_race", data_out, 8'h04);
    bus_write(3'd3, 8'h1F);
    buttons = 5'b00000;
    tick(DB + 3);

    // Interrupt on button 1 through the mask
    bus_write(3'd4, 8'h02);
    buttons = 5'b00010;
    tick(6);
    check("irq_before", {7'b0, irq}, 8'h00);
    tick();
    check("irq_asserted", {7'b0, irq}, {7'b0, IRQ_EN});
    bus_write(3'd3, 8'h02);
    tick();
    check("irq_cleared", {7'b0, irq}, 8'h00);
    buttons = 5'b00000;
    tick(DB + 3);

    // Random traffic against the reference model
    chk_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cs      = ($urandom_range(0, 2) != 0);
      we      = ($urandom_range(0, 3) == 0);
      addr    = 3'($urandom_range(0, 7));
      data_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) buttons[$urandom_range(0, 4)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) switches = 16'($urandom);
      tick();
    end
    chk_en = 1'b0;
    cs = 1'b0; we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_input_port6502
`default_nettype wire
